// File: rtl/pixel_pkg.sv
// Shared widths, screen defaults, pixel record and controller state encoding
// for the pixel writer block.
package pixel_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int X_W          = 8;
  localparam int Y_W          = 7;
  localparam int COL_W        = 3;
  localparam int PIX_W        = X_W + Y_W + COL_W;

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [COL_W-1:0] colour;
  } pix_t;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_EMPTY = 2'd1,
    ST_CLEAR      = 2'd2,
    ST_DONE       = 2'd3
  } state_e;

  function automatic logic in_screen(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                                     input int w, input int h);
    return (int'(x) < w) && (int'(y) < h);
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Power-of-two pixel FIFO with combinational read of the head entry.
// Pointers carry one extra wrap bit to tell full from empty.
module pixel_fifo
  import pixel_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = PIX_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Storage needs no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/pixel_writer.sv
// Buffers drawer pixels toward the VGA plot port, drops off-screen pixels and
// runs a raster full-screen fill on request after draining queued pixels.
module pixel_writer
  import pixel_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [X_W-1:0]   in_x,
  input  logic [Y_W-1:0]   in_y,
  input  logic [COL_W-1:0] in_colour,
  input  logic             clear_req,
  input  logic [COL_W-1:0] clear_colour,
  output logic [X_W-1:0]   x,
  output logic [Y_W-1:0]   y,
  output logic [COL_W-1:0] colour,
  output logic             writeEn,
  output logic             busy,
  output logic             clear_done
);

  localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);

  state_e           state_q;
  pix_t             in_pix;
  pix_t             fifo_dout;
  pix_t             pend_pix_q;
  logic             pend_vld_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             accept;
  logic             push;
  logic             pop;
  logic [COL_W-1:0] clr_col_q;
  logic [X_W-1:0]   sx_q, sx_d;
  logic [Y_W-1:0]   sy_q, sy_d;
  logic             sweep_last;
  logic [X_W-1:0]   x_q;
  logic [Y_W-1:0]   y_q;
  logic [COL_W-1:0] col_q;
  logic             we_q;
  logic             done_q;

  assign in_pix   = '{x: in_x, y: in_y, colour: in_colour};
  assign in_ready = !reset && !fifo_full && (state_q == ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign push     = accept && in_screen(in_x, in_y, SCREEN_W, SCREEN_H);
  assign pop      = !fifo_empty && ((state_q == ST_IDLE) || (state_q == ST_WAIT_EMPTY));

  pixel_fifo #(
    .DEPTH (DEPTH),
    .W     (PIX_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (in_pix),
    .rd_data (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    sx_d       = sx_q;
    sy_d       = sy_q;
    sweep_last = 1'b0;
    if (sx_q == X_LAST) begin
      sx_d = '0;
      if (sy_q == Y_LAST) sweep_last = 1'b1;
      else                sy_d = sy_q + Y_W'(1);
    end else begin
      sx_d = sx_q + X_W'(1);
    end
  end

  // Popped pixels spend one cycle in the pending stage before reaching the
  // plot registers, giving a fixed two-edge accept-to-plot latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pend_vld_q <= 1'b0;
      pend_pix_q <= '0;
      clr_col_q  <= '0;
      sx_q       <= '0;
      sy_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      col_q      <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      pend_vld_q <= pop;
      if (pop) pend_pix_q <= fifo_dout;
      if (pend_vld_q) begin
        we_q  <= 1'b1;
        x_q   <= pend_pix_q.x;
        y_q   <= pend_pix_q.y;
        col_q <= pend_pix_q.colour;
      end
      case (state_q)
        ST_IDLE: begin
          if (clear_req) begin
            clr_col_q <= clear_colour;
            state_q   <= ST_WAIT_EMPTY;
          end
        end
        ST_WAIT_EMPTY: begin
          if (fifo_empty && !pend_vld_q) begin
            sx_q    <= '0;
            sy_q    <= '0;
            state_q <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          we_q  <= 1'b1;
          x_q   <= sx_q;
          y_q   <= sy_q;
          col_q <= clr_col_q;
          sx_q  <= sx_d;
          sy_q  <= sy_d;
          if (sweep_last) state_q <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign colour     = col_q;
  assign writeEn    = we_q;
  assign clear_done = done_q;
  assign busy       = !fifo_empty || pend_vld_q || (state_q != ST_IDLE);

endmodule

// File: tb/tb_pixel_writer.sv
// Directed bench for pixel_writer: single-pixel vector table, streaming,
// full-screen clears with coincident pixels, re-request and mid-sweep reset.
module tb_pixel_writer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_x;
  logic [6:0] in_y;
  logic [2:0] in_colour;
  logic       clear_req;
  logic [2:0] clear_colour;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       writeEn;
  logic       busy;
  logic       clear_done;

  always #5 clk = ~clk;

  pixel_writer dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_x         (in_x),
    .in_y         (in_y),
    .in_colour    (in_colour),
    .clear_req    (clear_req),
    .clear_colour (clear_colour),
    .x            (x),
    .y            (y),
    .colour       (colour),
    .writeEn      (writeEn),
    .busy         (busy),
    .clear_done   (clear_done)
  );

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       exp_we;
  } vec_t;

  vec_t       vt[8];
  logic [7:0] pre_x[3];
  logic [6:0] pre_y[3];
  logic [2:0] pre_c[3];
  logic [7:0] lx;
  logic [6:0] ly;
  logic [2:0] lc;
  int         n_vec  = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Samples right after each edge (before stepping), so writes that happen
  // while the caller was still driving the request are not missed.
  task automatic watch_clear(input int n_pre, input logic [2:0] col, input bit inject);
    int wr = 0, cd = 0, post = 0, sx = 0, sy = 0;
    int pre_bad = 0, sweep_bad = 0, rdy_bad = 0, done_bad = 0;
    bit prev_we = 1'b0;
    for (int cyc = 0; cyc < 20500 && post < 4; cyc++) begin
      if (writeEn) begin
        if (wr < n_pre) begin
          if (x !== pre_x[wr] || y !== pre_y[wr] || colour !== pre_c[wr]) pre_bad++;
        end else begin
          if (x !== 8'(sx) || y !== 7'(sy) || colour !== col || sy > 119) sweep_bad++;
          sx++;
          if (sx == 160) begin
            sx = 0;
            sy++;
          end
        end
        wr++;
      end
      if (clear_done) begin
        cd++;
        if (!prev_we || writeEn || wr != n_pre + 19200 || !in_ready) done_bad++;
      end else if (cd == 0 && in_ready) begin
        rdy_bad++;
      end
      if (cd > 0) post++;
      prev_we      = writeEn;
      clear_req    = inject && (cyc == 5000);
      clear_colour = ~col;
      step();
      clear_req = 1'b0;
    end
    check("clear prefix pixels", pre_bad, 0);
    check("clear sweep order", sweep_bad, 0);
    check("clear total writes", wr, n_pre + 19200);
    check("clear_done count", cd, 1);
    check("clear_done timing", done_bad, 0);
    check("in_ready low while clearing", rdy_bad, 0);
    check("busy after clear", busy, 0);
    lx = 8'd159;
    ly = 7'd119;
    lc = col;
  endtask

  initial begin
    vt[0] = '{x: 8'd10,  y: 7'd20,  c: 3'b110, exp_we: 1'b1};
    vt[1] = '{x: 8'd0,   y: 7'd0,   c: 3'b001, exp_we: 1'b1};
    vt[2] = '{x: 8'd159, y: 7'd119, c: 3'b111, exp_we: 1'b1};
    vt[3] = '{x: 8'd160, y: 7'd5,   c: 3'b010, exp_we: 1'b0};
    vt[4] = '{x: 8'd7,   y: 7'd120, c: 3'b011, exp_we: 1'b0};
    vt[5] = '{x: 8'd255, y: 7'd127, c: 3'b101, exp_we: 1'b0};
    vt[6] = '{x: 8'd159, y: 7'd0,   c: 3'b100, exp_we: 1'b1};
    vt[7] = '{x: 8'd0,   y: 7'd119, c: 3'b010, exp_we: 1'b1};
    pre_x = '{8'd1, 8'd3, 8'd150};
    pre_y = '{7'd2, 7'd4, 7'd100};
    pre_c = '{3'b011, 3'b101, 3'b110};

    reset = 1'b1;
    in_valid = 1'b0; in_x = '0; in_y = '0; in_colour = '0;
    clear_req = 1'b0; clear_colour = '0;
    step();
    step();
    check("reset in_ready", in_ready, 0);
    check("reset plot", {writeEn, x, y, colour}, 0);
    check("reset busy", busy, 0);
    check("reset clear_done", clear_done, 0);
    reset = 1'b0;
    #1;
    check("in_ready after reset", in_ready, 1);
    lx = '0; ly = '0; lc = '0;

    // Single pixels: accept at edge t, plot after t+2, one cycle only.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_x = vt[i].x; in_y = vt[i].y; in_colour = vt[i].c;
      check("vec ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      check("vec we t+0", writeEn, 0);
      step();
      check("vec we t+1", writeEn, 0);
      step();
      check("vec we t+2", writeEn, vt[i].exp_we);
      if (vt[i].exp_we) begin
        lx = vt[i].x; ly = vt[i].y; lc = vt[i].c;
      end
      check("vec plot xyc", {x, y, colour}, {lx, ly, lc});
      step();
      check("vec we t+3", writeEn, 0);
      check("vec busy idle", busy, 0);
    end

    // Continuous stream of 12 pixels: ready never drops, order preserved.
    for (int c = 0; c < 16; c++) begin
      if (c < 12) begin
        in_valid = 1'b1; in_x = 8'(c * 3); in_y = 7'(c + 50); in_colour = 3'(c);
        check("stream ready", in_ready, 1);
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (c >= 2 && c < 14)
        check("stream plot", {writeEn, x, y, colour}, {1'b1, 8'((c - 2) * 3), 7'(c + 48), 3'(c - 2)});
      else
        check("stream idle we", writeEn, 0);
    end

    // Three pixels, the last coinciding with a black clear request.
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_x = pre_x[k]; in_y = pre_y[k]; in_colour = pre_c[k];
      clear_req = (k == 2); clear_colour = 3'b000;
      check("pre-clear ready", in_ready, 1);
      step();
    end
    in_valid = 1'b0; clear_req = 1'b0;
    watch_clear(3, 3'b000, 1'b0);

    // Clear with a second request mid-sweep that must be ignored.
    clear_req = 1'b1; clear_colour = 3'b101;
    step();
    clear_req = 1'b0;
    watch_clear(0, 3'b101, 1'b1);

    // Reset at sweep pixel (40,60) aborts without clear_done.
    begin
      bit found = 1'b0;
      int stray = 0;
      clear_req = 1'b1; clear_colour = 3'b011;
      step();
      clear_req = 1'b0;
      for (int c = 0; c < 20000 && !found; c++) begin
        if (writeEn && x == 8'd40 && y == 7'd60) found = 1'b1;
        else step();
      end
      check("reached sweep (40,60)", found, 1);
      check("sweep colour at abort", colour, 3'b011);
      reset = 1'b1;
      step();
      check("abort we", writeEn, 0);
      check("abort clear_done", clear_done, 0);
      check("abort busy", busy, 0);
      check("abort in_ready in reset", in_ready, 0);
      reset = 1'b0;
      #1;
      check("in_ready after abort", in_ready, 1);
      for (int c = 0; c < 300; c++) begin
        step();
        if (writeEn || clear_done || busy) stray++;
      end
      check("no activity after abort", stray, 0);
      in_valid = 1'b1; in_x = 8'd5; in_y = 7'd6; in_colour = 3'b010;
      step();
      in_valid = 1'b0;
      step();
      step();
      check("pixel after abort", {writeEn, x, y, colour}, {1'b1, 8'd5, 7'd6, 3'b010});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
